// File: rtl/synth_combiner.sv
// synth_combiner: serial synthesis combiner for the 16-band filterbank.
// It latches one frame of 16 subband samples (sfix35_En32) when sample_valid is
// seen in IDLE. It then accumulates frame[k]*gain[k] over 16 enabled cycles
// using a single multiplier. Finally it emits one rounded sfix14_En12 sample.
//
// Build option: define SYNTH_SAT_EN to saturate the output to [-8192, 8191].
// When it is undefined, the output wraps (low 14 bits of the shifted value).
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   clk_enable   qualifies all state/counter/output updates (not gain writes)
//   sample_valid frame strobe; subband_in valid this cycle
//   subband_in   16 x 35-bit signed subband samples, band 0..15
//   gain_we      gain table write strobe (ungated by clk_enable)
//   gain_addr    band index to write
//   gain_data    signed gain, sfix16_En14
//   filter_out   reconstructed sample, sfix14_En12
//   out_valid    one-enabled-cycle pulse when filter_out updates
//   busy         high while accumulating or emitting
//   overrun      sticky: strobe arrived while busy
module synth_combiner #(
  parameter int NBANDS     = 16,
  parameter int GAIN_RESET = 16384
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    sample_valid,
  input  logic [NBANDS-1:0][34:0] subband_in,
  input  logic                    gain_we,
  input  logic [3:0]              gain_addr,
  input  logic [15:0]             gain_data,
  output logic [13:0]             filter_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t             state;
  logic signed [34:0] frame [NBANDS];
  logic signed [15:0] gain  [NBANDS];
  logic signed [54:0] acc;
  logic [3:0]         idx;

  logic signed [50:0] product;
  logic signed [55:0] rounded;
  logic signed [21:0] shifted;
  logic [13:0]        requant;

  // The gain is read from the register, so a write landing on the same edge
  // as its use is not yet visible. The old value is used.
  assign product = frame[idx] * gain[idx];

  // Round half up at bit 33, then drop 34 fraction bits (En46 -> En12).
  assign rounded = {acc[54], acc} + 56'sd8589934592;
  assign shifted = rounded[55:34];

  always_comb begin
    requant = shifted[13:0];
`ifdef SYNTH_SAT_EN
    if (shifted > 22'sd8191)
      requant = 14'h1fff;
    else if (shifted < -22'sd8192)
      requant = 14'h2000;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NBANDS; i++)
        gain[i] <= 16'(GAIN_RESET);
    end else if (gain_we) begin
      gain[gain_addr] <= gain_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      filter_out <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < NBANDS; i++)
        frame[i] <= '0;
    end else if (clk_enable) begin
      out_valid <= 1'b0;
      if (sample_valid && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            for (int unsigned i = 0; i < NBANDS; i++)
              frame[i] <= subband_in[i];
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc + 55'(product);
          idx <= idx + 4'd1;
          if (idx == 4'd15)
            state <= OUT;
        end
        OUT: begin
          filter_out <= requant;
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_combiner.sv
module tb_synth_combiner;

  logic                clock = 1'b0;
  logic                reset;
  logic                clk_enable;
  logic                sample_valid;
  logic [15:0][34:0]   subband_in;
  logic                gain_we;
  logic [3:0]          gain_addr;
  logic [15:0]         gain_data;
  logic [13:0]         filter_out;
  logic                out_valid;
  logic                busy;
  logic                overrun;

  int n_cmp = 0;
  int n_bad = 0;

  synth_combiner #(.NBANDS(16), .GAIN_RESET(16384)) dut (
    .clock(clock), .reset(reset), .clk_enable(clk_enable),
    .sample_valid(sample_valid), .subband_in(subband_in),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
    .filter_out(filter_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    string  name;
    int     bi;     // band given bval
    longint bval;
    longint fill;   // value for every other band
    int     gi;     // gain index to program first (-1: none)
    int     gval;
    int     expv;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wgain(input int a, input int d);
    gain_we   = 1'b1;
    gain_addr = 4'(a);
    gain_data = 16'(d);
    tick();
    gain_we   = 1'b0;
  endtask

  task automatic load(input int bi, input longint bval, input longint fill);
    longint v;
    for (int i = 0; i < 16; i++) begin
      v = (i == bi) ? bval : fill;
      subband_in[i] = v[34:0];
    end
  endtask

  // Strobe a frame on E0, count enabled edges until out_valid.
  task automatic run_frame(input string name, input int expv, input bit gap,
                           input int wr_edge, input int wr_addr, input int wr_data,
                           input int ovr_edge);
    int lat;
    lat = 0;
    clk_enable   = 1'b1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (gap && (n == 3 || n == 10)) begin
        clk_enable = 1'b0;
        repeat (3) tick();
        clk_enable = 1'b1;
      end
      if (n == wr_edge) begin
        gain_we = 1'b1; gain_addr = 4'(wr_addr); gain_data = 16'(wr_data);
      end
      if (n == ovr_edge) begin
        sample_valid = 1'b1;
        load(-1, 0, 64'sd1 <<< 31);
      end
      tick();
      gain_we = 1'b0;
      sample_valid = 1'b0;
      if (n == 1) check({name, " busy_after_E0"}, busy, 1);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({name, " latency"}, lat, 17);
    check({name, " value"}, $signed(filter_out), expv);
    check({name, " busy_after"}, busy, 0);
    if (gap) begin
      clk_enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        check({name, " out_valid_hold"}, out_valid, 1);
      end
      clk_enable = 1'b1;
    end
    tick();
    check({name, " out_valid_pulse"}, out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; sample_valid = 1'b0;
    gain_we = 1'b0; gain_addr = '0; gain_data = '0;
    subband_in = '0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst filter_out", filter_out, 0);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst overrun", overrun, 0);

    vecs[0] = '{"unity_b0", 0, 64'sd1 <<< 32, 0, -1, 0, 4096};
`ifdef SYNTH_SAT_EN
    vecs[1] = '{"all_pos", 0, 64'sd1 <<< 32, 64'sd1 <<< 32, -1, 0, 8191};
    vecs[2] = '{"all_neg", 0, -(64'sd1 <<< 32), -(64'sd1 <<< 32), -1, 0, -8192};
`else
    vecs[1] = '{"all_pos", 0, 64'sd1 <<< 32, 64'sd1 <<< 32, -1, 0, 0};
    vecs[2] = '{"all_neg", 0, -(64'sd1 <<< 32), -(64'sd1 <<< 32), -1, 0, 0};
`endif
    vecs[3] = '{"rnd_half_up", 0, 64'sd1 <<< 19, 0, -1, 0, 1};
    vecs[4] = '{"rnd_neg_half", 0, -(64'sd1 <<< 19), 0, -1, 0, 0};
    vecs[5] = '{"rnd_below", 0, (64'sd1 <<< 19) - 1, 0, -1, 0, 0};
    vecs[6] = '{"neg_gain", 0, 64'sd1 <<< 32, 0, 0, -16384, -4096};
    vecs[7] = '{"gain3_half", 3, 64'sd1 <<< 32, 0, 3, 8192, 2048};

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].gi >= 0) wgain(vecs[v].gi, vecs[v].gval);
      load(vecs[v].bi, vecs[v].bval, vecs[v].fill);
      run_frame(vecs[v].name, vecs[v].expv, 1'b0, 0, 0, 0, 0);
      if (vecs[v].gi >= 0) wgain(vecs[v].gi, 16384);
    end

    // Write gain[5] on the same edge that reads it: old gain applies.
    load(5, 64'sd1 <<< 32, 0);
    run_frame("wr_same_edge", 4096, 1'b0, 6, 5, 0, 0);
    wgain(5, 16384);
    // Write landing one edge earlier: new gain applies.
    load(5, 64'sd1 <<< 32, 0);
    run_frame("wr_early", 2048, 1'b0, 5, 5, 8192, 0);
    wgain(5, 16384);

    // Clock-enable gaps must not change result or enabled-edge latency.
    load(0, 64'sd1 <<< 32, 0);
    run_frame("gaps", 4096, 1'b1, 0, 0, 0, 0);

    // Second strobe at E5 is ignored and flags overrun.
    check("pre overrun", overrun, 0);
    load(0, 64'sd1 <<< 32, 0);
    run_frame("overrun_frame", 4096, 1'b0, 0, 0, 0, 5);
    check("overrun sticky", overrun, 1);

    // Reset at E8 of a frame with gain[3] reprogrammed.
    wgain(3, 0);
    load(3, 64'sd1 <<< 32, 0);
    clk_enable = 1'b1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
        tick();
        if (out_valid) seen++;
      end
      check("rst_mid no out_valid", seen, 0);
    end
    check("rst_mid filter_out", filter_out, 0);
    check("rst_mid overrun", overrun, 0);
    check("rst_mid busy", busy, 0);
    // gain[3] back to unity proves the table was reset.
    run_frame("after_reset", 4096, 1'b0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
